// File: rtl/data_mem_unit_pkg.sv
// Shared encodings for the data memory unit: access sizes, FSM states, error causes.
package data_mem_unit_pkg;

  localparam int unsigned SIZE_W = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 32;
  localparam int unsigned ERR_W  = 3;

  // Access size encodings on req_size
  localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
  localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
  localparam logic [SIZE_W-1:0] SZ_W = 2'd2;
  localparam logic [SIZE_W-1:0] SZ_D = 2'd3;

  // Request FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Error cause bits; any set bit reports resp_err
  localparam logic [ERR_W-1:0] ERR_NONE     = 3'b000;
  localparam logic [ERR_W-1:0] ERR_SIZE     = 3'b001;
  localparam logic [ERR_W-1:0] ERR_MISALIGN = 3'b010;
  localparam logic [ERR_W-1:0] ERR_RANGE    = 3'b100;

endpackage

// File: rtl/data_mem_unit_lane_align.sv
// Combinational byte-lane store merge and load extract/extend for one XLEN word.
module dmem_lane_align
  import data_mem_unit_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0]              word_i,
  input  logic [$clog2(XLEN/8)-1:0]    lane_i,
  input  logic [SIZE_W-1:0]            size_i,
  input  logic                         unsigned_i,
  input  logic [XLEN-1:0]              wdata_i,
  output logic [XLEN-1:0]              merged_o,
  output logic [XLEN-1:0]              load_o
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LW = $clog2(NB);

  logic [LW+2:0]   shamt;
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] wd_shift;
  logic [3:0]      nbytes;

  // Store merge: replace only the addressed lanes, keep the rest of the word
  always_comb begin
    shamt    = {lane_i, 3'b000};
    rd_shift = word_i >> shamt;
    wd_shift = wdata_i << shamt;
    nbytes   = 4'd1 << size_i;
    merged_o = word_i;
    for (int unsigned b = 0; b < NB; b++) begin
      if ((b >= 32'(lane_i)) && (b < (32'(lane_i) + 32'(nbytes)))) begin
        merged_o[8*b +: 8] = wd_shift[8*b +: 8];
      end
    end
  end

  // Load extract: lanes already shifted down, extend from the access width
  always_comb begin
    load_o = rd_shift;
    case (size_i)
      SZ_B:    load_o = unsigned_i ? XLEN'(rd_shift[7:0])  : XLEN'($signed(rd_shift[7:0]));
      SZ_H:    load_o = unsigned_i ? XLEN'(rd_shift[15:0]) : XLEN'($signed(rd_shift[15:0]));
      SZ_W:    load_o = unsigned_i ? XLEN'(rd_shift[31:0]) : XLEN'($signed(rd_shift[31:0]));
      default: load_o = rd_shift;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Multi-cycle load/store data memory with valid/ready request and one-cycle response.
// Optional statistics counters: define DMEM_STATS_EN.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              busy
`ifdef DMEM_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_loads,
  output logic [STAT_W-1:0] stat_stores,
  output logic [STAT_W-1:0] stat_errors
`endif
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LW = $clog2(NB);
  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              uns_q, uns_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              rvalid_q, rvalid_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              commit;

  logic [XLEN-1:0]   mem_q [DEPTH_WORDS];
  logic [IW-1:0]     word_idx;
  logic [XLEN-1:0]   rd_word;
  logic [XLEN-1:0]   merged;
  logic [XLEN-1:0]   load_data;
  logic [ERR_W-1:0]  err_cause;
  logic              err_any;

  // Error classification of the latched request
  always_comb begin
    err_cause = ERR_NONE;
    if ((XLEN == 32) && (size_q == SZ_D)) err_cause = err_cause | ERR_SIZE;
    if ((addr_q[2:0] & 3'((4'd1 << size_q) - 4'd1)) != 3'd0) err_cause = err_cause | ERR_MISALIGN;
    if ((addr_q >> LW) >= XLEN'(DEPTH_WORDS)) err_cause = err_cause | ERR_RANGE;
    err_any  = (err_cause != ERR_NONE);
    word_idx = addr_q[LW +: IW];
    rd_word  = mem_q[word_idx];
  end

  dmem_lane_align #(.XLEN(XLEN)) u_align (
    .word_i     (rd_word),
    .lane_i     (addr_q[LW-1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .merged_o   (merged),
    .load_o     (load_data)
  );

  // Next-state, request latch and response generation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    err_d    = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(LATENCY);
          state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d  = ST_IDLE;
        commit   = 1'b1;
        rvalid_d = 1'b1;
        err_d    = err_any;
        rdata_d  = (err_any || we_q) ? '0 : load_data;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // Control and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Array write commits only on the response edge of an error-free store
  always_ff @(posedge clock) begin
    if (commit && we_q && !err_any) mem_q[word_idx] <= merged;
  end

  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

`ifdef DMEM_STATS_EN
  logic [STAT_W-1:0] loads_q, stores_q, errors_q;

  // Saturating per-type request counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      loads_q  <= '0;
      stores_q <= '0;
      errors_q <= '0;
    end else if (commit) begin
      if (err_any) begin
        if (errors_q != '1) errors_q <= errors_q + STAT_W'(1);
      end else if (we_q) begin
        if (stores_q != '1) stores_q <= stores_q + STAT_W'(1);
      end else begin
        if (loads_q != '1) loads_q <= loads_q + STAT_W'(1);
      end
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errors = errors_q;
`endif

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: three instances with LATENCY 1, 3 and 0.
module tb_data_mem_unit;
  import data_mem_unit_pkg::*;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic        clock;
  logic        rst   [3];
  logic        vld   [3];
  logic        rdy   [3];
  logic        we_r  [3];
  logic [1:0]  sz    [3];
  logic        uns   [3];
  logic [63:0] addr  [3];
  logic [63:0] wdat  [3];
  logic        rvld  [3];
  logic [63:0] rdat  [3];
  logic        rerr  [3];
  logic        bsy   [3];
`ifdef DMEM_STATS_EN
  logic [31:0] st_l  [3];
  logic [31:0] st_s  [3];
  logic [31:0] st_e  [3];
`endif

  exp_t        sbq [3][$];
  logic [7:0]  mdl [3][8192];
  int          last_acc [3];
  int          cyc = 0;
  int          vectors = 0;
  int          fails = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    data_mem_unit #(.XLEN(64), .DEPTH_WORDS(1024), .LATENCY(L)) u_dut (
      .clock        (clock),
      .reset        (rst[g]),
      .req_valid    (vld[g]),
      .req_ready    (rdy[g]),
      .req_we       (we_r[g]),
      .req_size     (sz[g]),
      .req_unsigned (uns[g]),
      .req_addr     (addr[g]),
      .req_wdata    (wdat[g]),
      .resp_valid   (rvld[g]),
      .resp_rdata   (rdat[g]),
      .resp_err     (rerr[g]),
      .busy         (bsy[g])
`ifdef DMEM_STATS_EN
      ,
      .stat_loads   (st_l[g]),
      .stat_stores  (st_s[g]),
      .stat_errors  (st_e[g])
`endif
    );
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
  endfunction

  task automatic chk(input int i, input string nm, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, i, act, expv);
    end
  endtask

  // Reference: byte-addressed little-endian array with the documented error rules
  function automatic void model(input int i, input logic we, input logic [1:0] s, input logic u,
                                input logic [63:0] a, input logic [63:0] wd,
                                output logic [63:0] rd, output logic err);
    int n;
    int base;
    n    = 1 << s;
    err  = ((a % 64'(n)) != 64'd0) || ((a / 64'd8) >= 64'd1024);
    rd   = '0;
    if (err) return;
    base = int'(a[12:0]);
    for (int k = 0; k < n; k++) begin
      if (we) mdl[i][base + k] = wd[8*k +: 8];
      else    rd = rd | (64'(mdl[i][base + k]) << (8*k));
    end
    if (!we && !u && (n < 8) && rd[8*n - 1]) rd = rd | (~64'd0 << (8*n));
  endfunction

  task automatic check_reset_vals(input int i);
    chk(i, "rst_ready", 64'(rdy[i]), 64'd1);
    chk(i, "rst_resp_valid", 64'(rvld[i]), 64'd0);
    chk(i, "rst_rdata", rdat[i], 64'd0);
    chk(i, "rst_err", 64'(rerr[i]), 64'd0);
    chk(i, "rst_busy", 64'(bsy[i]), 64'd0);
`ifdef DMEM_STATS_EN
    chk(i, "rst_stat_loads", 64'(st_l[i]), 64'd0);
    chk(i, "rst_stat_stores", 64'(st_s[i]), 64'd0);
    chk(i, "rst_stat_errors", 64'(st_e[i]), 64'd0);
`endif
  endtask

  // Present a request at a falling edge, wait for acceptance, optionally keep valid high
  task automatic issue(input int i, input logic we, input logic [1:0] s, input logic u,
                       input logic [63:0] a, input logic [63:0] wd,
                       input bit keep, input bit track, input int gap);
    exp_t e;
    int   t;
    vld[i] = 1'b1; we_r[i] = we; sz[i] = s; uns[i] = u; addr[i] = a; wdat[i] = wd;
    t = 0;
    while (!rdy[i] && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (!rdy[i]) begin
      chk(i, "accept_timeout", 64'd0, 64'd1);
      vld[i] = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    if (gap != 0) chk(i, "accept_gap", 64'(e.acc - last_acc[i]), 64'(gap));
    last_acc[i] = e.acc;
    if (track) model(i, we, s, u, a, wd, e.rdata, e.err);
    @(posedge clock);
    if (track) sbq[i].push_back(e);
    @(negedge clock);
    if (!keep) begin
      vld[i]  = 1'b0;
      we_r[i] = 1'($urandom);
      sz[i]   = 2'($urandom);
      addr[i] = {$urandom, $urandom};
      wdat[i] = {$urandom, $urandom};
    end
  endtask

  task automatic rand_req(input int i, input bit keep, input int gap);
    logic [63:0] a;
    if ($urandom_range(0, 9) == 0) a = 64'd8192 + 64'($urandom_range(0, 63));
    else                           a = 64'($urandom_range(0, 63));
    issue(i, 1'($urandom), 2'($urandom), 1'($urandom), a, {$urandom, $urandom}, keep, 1'b1, gap);
  endtask

  task automatic drain(input int i);
    int t;
    t = 0;
    while (sbq[i].size() != 0 && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (sbq[i].size() != 0) begin
      chk(i, "drain_timeout", 64'(sbq[i].size()), 64'd0);
      sbq[i].delete();
    end
  endtask

  // Monitor: pop expected response on every resp_valid, check in-flight handshake otherwise
  always @(negedge clock) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) continue;
      if (rvld[i]) begin
        if (sbq[i].size() == 0) begin
          chk(i, "unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = sbq[i].pop_front();
          chk(i, "rdata", rdat[i], e.rdata);
          chk(i, "err", 64'(rerr[i]), 64'(e.err));
          chk(i, "latency", 64'(cyc - e.acc), 64'(lat_of(i) + 1));
        end
      end else if (sbq[i].size() != 0) begin
        chk(i, "ready_in_flight", 64'(rdy[i]), 64'd0);
        chk(i, "busy_in_flight", 64'(bsy[i]), 64'd1);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; vld[i] = 1'b0; we_r[i] = 1'b0; sz[i] = 2'd0; uns[i] = 1'b0;
      addr[i] = '0; wdat[i] = '0; last_acc[i] = 0;
    end
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) check_reset_vals(i);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge clock);

    // Known contents for the low 64 bytes of each array
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 8; w++)
        issue(i, 1'b1, SZ_D, 1'b0, 64'(w * 8), {$urandom, $urandom}, 1'b0, 1'b1, 0);
      drain(i);
    end

    // Directed on LATENCY=1
    issue(0, 1'b1, SZ_D, 1'b0, 64'h8, 64'h1122334455667788, 1'b0, 1'b1, 0);
    issue(0, 1'b0, SZ_D, 1'b0, 64'h8, 64'h0, 1'b0, 1'b1, 0);
    issue(0, 1'b1, SZ_H, 1'b0, 64'hC, 64'h000000000000BEEF, 1'b0, 1'b1, 0);
    issue(0, 1'b0, SZ_D, 1'b0, 64'h8, 64'h0, 1'b0, 1'b1, 0);
    issue(0, 1'b1, SZ_B, 1'b0, 64'h10, 64'h0000000000000080, 1'b0, 1'b1, 0);
    issue(0, 1'b0, SZ_B, 1'b0, 64'h10, 64'h0, 1'b0, 1'b1, 0);
    issue(0, 1'b0, SZ_B, 1'b1, 64'h10, 64'h0, 1'b0, 1'b1, 0);
    issue(0, 1'b0, SZ_D, 1'b0, 64'h10, 64'h0, 1'b0, 1'b1, 0);
    issue(0, 1'b0, SZ_H, 1'b0, 64'h3, 64'h0, 1'b0, 1'b1, 0);
    issue(0, 1'b1, SZ_D, 1'b0, 64'd8192, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 0);
    issue(0, 1'b0, SZ_D, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 0);
    for (int n = 0; n < 150; n++) rand_req(0, 1'b0, 0);
    drain(0);

    // LATENCY=3: random traffic, then reset during WAIT of a store
    for (int n = 0; n < 30; n++) rand_req(1, 1'b0, 0);
    drain(1);
    issue(1, 1'b1, SZ_D, 1'b0, 64'h20, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b0, 0);
    #2 rst[1] = 1'b1;
    #1 check_reset_vals(1);
    @(negedge clock);
    rst[1] = 1'b0;
    repeat (6) @(negedge clock);
    issue(1, 1'b0, SZ_D, 1'b0, 64'h20, 64'h0, 1'b0, 1'b1, 0);
    drain(1);

    // LATENCY=0 with valid held high: one accept every two cycles
    rand_req(2, 1'b1, 0);
    for (int n = 0; n < 40; n++) rand_req(2, 1'b1, 2);
    rand_req(2, 1'b0, 2);
    drain(2);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
